sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 99 +++++++++
 tb/tb_sw_debounce.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit debouncer for a bus of board switches.
// Each raw switch bit is synchronised into clk_i by two flops and then sampled
// on a shared prescaler tick. A bit's registered output takes a new level only
// after STABLE_TICKS consecutive ticks disagree with the current output. For
// that bit, sw_chg_o pulses for the one cycle in which the new level first
// appears on io_sw_o.
module sw_debounce #(
    parameter int W            = 32,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] sw_raw_i,
    output logic [W-1:0] io_sw_o,
    output logic [W-1:0] sw_chg_o
);

    // Prescaler and stability-counter widths. The minimum is 1 bit, so the
    // degenerate parameter values 1 still give legal vectors.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

    logic [W-1:0]          sync1_q, sync1_d;
    logic [W-1:0]          sync2_q, sync2_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [W-1:0][CW-1:0]  cnt_q,   cnt_d;
    logic [W-1:0]          io_sw_q, io_sw_d;
    logic [W-1:0]          chg_q,   chg_d;
    logic                  tick_s;

    // The tick is a decode of the prescaler terminal count. With TICK_DIV = 1
    // the prescaler stays at 0, so the tick is high every cycle.
    assign tick_s = (presc_q == PRESC_MAX);

    // Synchroniser and prescaler next-state logic.
    always_comb begin
        sync1_d = sw_raw_i;
        sync2_d = sync1_q;
        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Per-bit stability counting. On a tick edge a bit either clears its
    // counter when the input matches the output, or advances its counter.
    // When the counter reaches its last step, the bit accepts the new level.
    // Between ticks everything holds.
    always_comb begin
        cnt_d   = cnt_q;
        io_sw_d = io_sw_q;
        chg_d   = {W{1'b0}};
        if (tick_s) begin
            for (int b = 0; b < W; b++) begin
                if (sync2_q[b] == io_sw_q[b]) begin
                    cnt_d[b] = {CW{1'b0}};
                end else if (cnt_q[b] == CNT_MAX) begin
                    io_sw_d[b] = sync2_q[b];
                    cnt_d[b]   = {CW{1'b0}};
                    chg_d[b]   = 1'b1;
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end
        end else begin
            cnt_d   = cnt_q;
            io_sw_d = io_sw_q;
        end
    end

    // State registers. An asynchronous reset clears all history, including
    // any partial counts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= {W{1'b0}};
            sync2_q <= {W{1'b0}};
            presc_q <= {PW{1'b0}};
            cnt_q   <= '0;
            io_sw_q <= {W{1'b0}};
            chg_q   <= {W{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            io_sw_q <= io_sw_d;
            chg_q   <= chg_d;
        end
    end

    assign io_sw_o  = io_sw_q;
    assign sw_chg_o = chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_DIV=4, STABLE_TICKS=3, W=32.
// A clean step must reach io_sw_o 11..14 clock edges after it is applied.
// Two cycles go to synchronisation. The first tick follows within 4 edges,
// and two more ticks add 8 edges.
// Right after a reset release the prescaler phase is known. In that case the
// update lands on exactly edge 12, the third tick after release.
module tb_sw_debounce;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] sw_raw_i;
    logic [31:0] io_sw_o;
    logic [31:0] sw_chg_o;

    int vectors     = 0;
    int miscompares = 0;

    sw_debounce #(
        .W            (32),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sw_raw_i (sw_raw_i),
        .io_sw_o  (io_sw_o),
        .sw_chg_o (sw_chg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Applies a new raw value and waits (bounded) for io_sw_o to move.
    // It then checks the new value, the change pulse, the latency, that no
    // early pulse occurred, and that the pulse drops after one cycle.
    task automatic measure(input string tag, input logic [31:0] raw,
                           input logic [31:0] exp_io, input logic [31:0] exp_chg,
                           input int lo, input int hi);
        logic [31:0] prev;
        logic [31:0] early;
        int          lat;
        prev     = io_sw_o;
        early    = 32'h0;
        lat      = 0;
        sw_raw_i = raw;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i);
            #1;
            if (io_sw_o !== prev) begin
                lat = i;
                break;
            end
            early = early | sw_chg_o;
        end
        chk({tag, "_io"}, io_sw_o, exp_io);
        chk({tag, "_chg"}, sw_chg_o, exp_chg);
        chk_range({tag, "_latency"}, lat, lo, hi);
        chk({tag, "_early_chg"}, early, 32'h0);
        @(posedge clk_i);
        #1;
        chk({tag, "_chg_drop"}, sw_chg_o, 32'h0);
        chk({tag, "_io_hold"}, io_sw_o, exp_io);
    endtask

    initial begin
        logic [31:0] quiet;

        // Reset state.
        rst_i    = 1'b1;
        sw_raw_i = 32'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_io", io_sw_o, 32'h0);
        chk("reset_chg", sw_chg_o, 32'h0);
        rst_i = 1'b0;

        // Clean step on bit 0, then release.
        measure("step0", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 11, 14);
        @(negedge clk_i);
        measure("fall0", 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 11, 14);

        // Bounce bit 0 every 3 cycles for 40 cycles. Ticks every 4 cycles can
        // never see three consecutive highs, so nothing may move.
        @(negedge clk_i);
        quiet = 32'h0;
        for (int c = 0; c < 40; c++) begin
            sw_raw_i = (((c / 3) % 2) == 0) ? 32'h0000_0001 : 32'h0000_0000;
            @(posedge clk_i);
            #1;
            quiet = quiet | io_sw_o | sw_chg_o;
        end
        chk("bounce_quiet", quiet, 32'h0);
        measure("bounce_hold", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1, 14);
        @(negedge clk_i);
        measure("bounce_fall", 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 11, 14);

        // Single-tick glitch on bit 5.
        @(negedge clk_i);
        quiet    = 32'h0;
        sw_raw_i = 32'h0000_0020;
        for (int c = 0; c < 34; c++) begin
            if (c == 4) sw_raw_i = 32'h0000_0000;
            @(posedge clk_i);
            #1;
            quiet = quiet | io_sw_o | sw_chg_o;
        end
        chk("glitch_quiet", quiet, 32'h0);

        // All bits change together.
        @(negedge clk_i);
        measure("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 11, 14);

        // Asynchronous reset clears outputs without a clock edge.
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("async_rst_io", io_sw_o, 32'h0);
        chk("async_rst_chg", sw_chg_o, 32'h0);
        sw_raw_i = 32'h0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Bit 3 is partway through its count when reset hits. The restart needs
        // the full latency: ticks fall on edges 4, 8 and 12 after release.
        sw_raw_i = 32'h0000_0008;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("mid_pre_rst_io", io_sw_o, 32'h0);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_io", io_sw_o, 32'h0);
        chk("mid_rst_chg", sw_chg_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        measure("rst_restart", 32'h0000_0008, 32'h0000_0008, 32'h0000_0008, 12, 12);

        // Release bit 3.
        @(negedge clk_i);
        measure("release3", 32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 11, 14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
